// File: rtl/regfile_writeback_pkg.sv
// Shared widths, tag encoding and register indices for the register file,
// read mux and issue logic.
package regfile_writeback_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int NREGS  = 6;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam logic [3:0] REG_R1 = 4'd1;
  localparam logic [3:0] REG_R2 = 4'd2;
  localparam logic [3:0] REG_R3 = 4'd3;
  localparam logic [3:0] REG_R4 = 4'd4;
  localparam logic [3:0] REG_R5 = 4'd5;
  localparam logic [3:0] REG_R6 = 4'd6;
endpackage

// File: rtl/regfile_writeback_entry.sv
// One architectural register and its status tag (Qi).
// Exposes its next-state tag so the top can count pending registers.
module regfile_entry
  import regfile_writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              init_sel,
  input  logic [DATA_W-1:0] init_data,
  input  logic              issue_sel,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] value,
  output logic [TAG_W-1:0]  tag,
  output logic [TAG_W-1:0]  tag_nxt,
  output logic              match
);
  logic [DATA_W-1:0] val_nxt;

  assign match = cdb_valid && (cdb_tag != TAG_NONE) && (tag == cdb_tag);

  // Qi priority: init > issue > CDB; value priority: init > CDB.
  always_comb begin
    val_nxt = value;
    tag_nxt = tag;
    if (match) begin
      val_nxt = cdb_data;
      tag_nxt = TAG_NONE;
    end
    if (issue_sel) tag_nxt = issue_tag;
    if (init_sel) begin
      val_nxt = init_data;
      tag_nxt = TAG_NONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      tag   <= TAG_NONE;
    end else begin
      value <= val_nxt;
      tag   <= tag_nxt;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Write side of the Tomasulo register file: init/issue index decode,
// error flagging, CDB ack and pending-reservation count around NREGS entries.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              init_valid,
  input  logic [3:0]        init_reg,
  input  logic [DATA_W-1:0] init_data,
  input  logic              issue_valid,
  input  logic [3:0]        issue_reg,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              cdb_ack,
  output logic              err_pulse,
  output logic [DATA_W-1:0] r1, r2, r3, r4, r5, r6,
  output logic [TAG_W-1:0]  q1, q2, q3, q4, q5, q6,
  output logic [2:0]        pending
);
  logic [NREGS-1:0][DATA_W-1:0] rv;
  logic [NREGS-1:0][TAG_W-1:0]  qv, qv_nxt;
  logic [NREGS-1:0]             init_sel, issue_sel, match;
  logic                         init_legal, issue_legal, init_ok, issue_ok, err;
  logic [2:0]                   cnt;

  assign init_legal  = (init_reg  >= 4'd1) && (init_reg  <= 4'(NREGS));
  assign issue_legal = (issue_reg >= 4'd1) && (issue_reg <= 4'(NREGS));
  assign init_ok     = init_valid && init_legal;
  assign issue_ok    = issue_valid && issue_legal && (issue_tag != TAG_NONE);

  assign err = (init_valid && !init_legal)
             || (issue_valid && (!issue_legal || issue_tag == TAG_NONE))
             || (cdb_valid && cdb_tag == TAG_NONE);

  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    assign init_sel[i]  = init_ok  && (init_reg  == 4'(i + 1));
    assign issue_sel[i] = issue_ok && (issue_reg == 4'(i + 1));

    regfile_entry u_ent (
      .clock     (clock),
      .reset     (reset),
      .init_sel  (init_sel[i]),
      .init_data (init_data),
      .issue_sel (issue_sel[i]),
      .issue_tag (issue_tag),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .value     (rv[i]),
      .tag       (qv[i]),
      .tag_nxt   (qv_nxt[i]),
      .match     (match[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt = cnt + 3'(qv_nxt[i] != TAG_NONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_ack   <= 1'b0;
      err_pulse <= 1'b0;
      pending   <= '0;
    end else begin
      cdb_ack   <= |match;
      err_pulse <= err;
      pending   <= cnt;
    end
  end

  assign r1 = rv[REG_R1-1]; assign q1 = qv[REG_R1-1];
  assign r2 = rv[REG_R2-1]; assign q2 = qv[REG_R2-1];
  assign r3 = rv[REG_R3-1]; assign q3 = qv[REG_R3-1];
  assign r4 = rv[REG_R4-1]; assign q4 = qv[REG_R4-1];
  assign r5 = rv[REG_R5-1]; assign q5 = qv[REG_R5-1];
  assign r6 = rv[REG_R6-1]; assign q6 = qv[REG_R6-1];
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, issue/CDB flow, multi-match,
// renaming, same-cycle collisions, priorities and illegal requests.
module tb_regfile_writeback;
  logic        clock = 0, reset = 1;
  logic        init_valid = 0, issue_valid = 0, cdb_valid = 0;
  logic [3:0]  init_reg = 0, issue_reg = 0;
  logic [15:0] init_data = 0, cdb_data = 0;
  logic [2:0]  issue_tag = 0, cdb_tag = 0;
  logic        cdb_ack, err_pulse;
  logic [15:0] r1, r2, r3, r4, r5, r6;
  logic [2:0]  q1, q2, q3, q4, q5, q6;
  logic [2:0]  pending;
  int total = 0, bad = 0;

  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .init_valid(init_valid), .init_reg(init_reg), .init_data(init_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_ack(cdb_ack), .err_pulse(err_pulse),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6),
    .pending(pending)
  );

  always #5 clock = ~clock;

  // Apply the currently driven inputs for one edge, then return inputs to idle.
  task automatic step();
    @(posedge clock); #1;
    init_valid = 0; issue_valid = 0; cdb_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 0;
    init_valid = 1; init_reg = 2; init_data = 16'h1234;
    issue_valid = 1; issue_reg = 3; issue_tag = 5;
    step();
    total++; if (r2 !== 16'h1234) begin bad++; $display("FAIL reset_pre_r2 got=%h exp=1234", r2); end
    total++; if (q3 !== 3'd5) begin bad++; $display("FAIL reset_pre_q3 got=%0d exp=5", q3); end
    #2 reset = 1; #1;
    total++; if (r2 !== 16'h0) begin bad++; $display("FAIL reset_r2 got=%h exp=0", r2); end
    total++; if (q3 !== 3'd0) begin bad++; $display("FAIL reset_q3 got=%0d exp=0", q3); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    total++; if (cdb_ack !== 1'b0 || err_pulse !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", cdb_ack, err_pulse); end
    @(negedge clock); reset = 0;
  endtask

  task automatic test_init_issue_cdb();
    init_valid = 1; init_reg = 4; init_data = 16'hBEEF; step();
    total++; if (r4 !== 16'hBEEF) begin bad++; $display("FAIL init_r4 got=%h exp=beef", r4); end
    issue_valid = 1; issue_reg = 4; issue_tag = 2; step();
    total++; if (q4 !== 3'd2) begin bad++; $display("FAIL issue_q4 got=%0d exp=2", q4); end
    total++; if (pending !== 3'd1) begin bad++; $display("FAIL issue_pending got=%0d exp=1", pending); end
    total++; if (r4 !== 16'hBEEF) begin bad++; $display("FAIL issue_r4_kept got=%h exp=beef", r4); end
    cdb_valid = 1; cdb_tag = 2; cdb_data = 16'h00AA; step();
    total++; if (r4 !== 16'h00AA) begin bad++; $display("FAIL cdb_r4 got=%h exp=00aa", r4); end
    total++; if (q4 !== 3'd0) begin bad++; $display("FAIL cdb_q4 got=%0d exp=0", q4); end
    total++; if (cdb_ack !== 1'b1) begin bad++; $display("FAIL cdb_ack got=%b exp=1", cdb_ack); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL cdb_pending got=%0d exp=0", pending); end
    step();
    total++; if (cdb_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse got=%b exp=0", cdb_ack); end
  endtask

  task automatic test_multi_match();
    issue_valid = 1; issue_reg = 1; issue_tag = 3; step();
    issue_valid = 1; issue_reg = 5; issue_tag = 3; step();
    total++; if (pending !== 3'd2) begin bad++; $display("FAIL multi_pending2 got=%0d exp=2", pending); end
    cdb_valid = 1; cdb_tag = 3; cdb_data = 16'h0F0F; step();
    total++; if (r1 !== 16'h0F0F || r5 !== 16'h0F0F) begin bad++; $display("FAIL multi_r got=%h,%h exp=0f0f,0f0f", r1, r5); end
    total++; if (q1 !== 3'd0 || q5 !== 3'd0) begin bad++; $display("FAIL multi_q got=%0d,%0d exp=0,0", q1, q5); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL multi_pending0 got=%0d exp=0", pending); end
    total++; if (cdb_ack !== 1'b1) begin bad++; $display("FAIL multi_ack got=%b exp=1", cdb_ack); end
  endtask

  task automatic test_rename();
    issue_valid = 1; issue_reg = 2; issue_tag = 1; step();
    issue_valid = 1; issue_reg = 2; issue_tag = 4; step();
    total++; if (q2 !== 3'd4) begin bad++; $display("FAIL rename_q2 got=%0d exp=4", q2); end
    cdb_valid = 1; cdb_tag = 1; cdb_data = 16'h1111; step();
    total++; if (r2 !== 16'h0) begin bad++; $display("FAIL rename_stale_r2 got=%h exp=0000", r2); end
    total++; if (q2 !== 3'd4) begin bad++; $display("FAIL rename_stale_q2 got=%0d exp=4", q2); end
    total++; if (cdb_ack !== 1'b0) begin bad++; $display("FAIL rename_stale_ack got=%b exp=0", cdb_ack); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL rename_err got=%b exp=0", err_pulse); end
    cdb_valid = 1; cdb_tag = 4; cdb_data = 16'h4444; step();
    total++; if (r2 !== 16'h4444 || q2 !== 3'd0) begin bad++; $display("FAIL rename_r2 got=%h/%0d exp=4444/0", r2, q2); end
  endtask

  task automatic test_same_cycle();
    issue_valid = 1; issue_reg = 6; issue_tag = 2; step();
    issue_valid = 1; issue_reg = 6; issue_tag = 5;
    cdb_valid = 1; cdb_tag = 2; cdb_data = 16'h2222; step();
    total++; if (r6 !== 16'h2222) begin bad++; $display("FAIL same_r6 got=%h exp=2222", r6); end
    total++; if (q6 !== 3'd5) begin bad++; $display("FAIL same_q6 got=%0d exp=5", q6); end
    total++; if (cdb_ack !== 1'b1) begin bad++; $display("FAIL same_ack got=%b exp=1", cdb_ack); end
    total++; if (pending !== 3'd1) begin bad++; $display("FAIL same_pending got=%0d exp=1", pending); end
  endtask

  // Issue reg0 / reg7 / tag0, init reg0, CDB tag0: each ignored, one-cycle error.
  task automatic test_errors();
    logic [3:0] regs [5] = '{4'd0, 4'd7, 4'd3, 4'd0, 4'd1};
    logic [2:0] tags [5] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin issue_valid = 1; issue_reg = regs[k]; issue_tag = tags[k]; end
      else if (k == 3) begin init_valid = 1; init_reg = regs[k]; init_data = 16'hDEAD; end
      else begin cdb_valid = 1; cdb_tag = 0; cdb_data = 16'hDEAD; end
      step();
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL err_set[%0d] got=%b exp=1", k, err_pulse); end
      total++; if (pending !== 3'd1 || q3 !== 3'd0 || q6 !== 3'd5) begin bad++; $display("FAIL err_state[%0d] got=%0d/%0d/%0d exp=1/0/5", k, pending, q3, q6); end
      total++; if (r1 !== 16'h0F0F || r3 !== 16'h0) begin bad++; $display("FAIL err_r[%0d] got=%h,%h exp=0f0f,0000", k, r1, r3); end
      step();
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_clr[%0d] got=%b exp=0", k, err_pulse); end
    end
  endtask

  task automatic test_priority();
    init_valid = 1; init_reg = 3; init_data = 16'h3333;
    issue_valid = 1; issue_reg = 3; issue_tag = 6; step();
    total++; if (r3 !== 16'h3333 || q3 !== 3'd0) begin bad++; $display("FAIL prio_init_issue got=%h/%0d exp=3333/0", r3, q3); end
    init_valid = 1; init_reg = 6; init_data = 16'h6666;
    cdb_valid = 1; cdb_tag = 5; cdb_data = 16'h5555; step();
    total++; if (r6 !== 16'h6666 || q6 !== 3'd0) begin bad++; $display("FAIL prio_init_cdb got=%h/%0d exp=6666/0", r6, q6); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL prio_pending got=%0d exp=0", pending); end
    for (int k = 1; k <= 6; k++) begin
      issue_valid = 1; issue_reg = 4'(k); issue_tag = 3'(k); step();
    end
    total++; if (pending !== 3'd6) begin bad++; $display("FAIL full_pending got=%0d exp=6", pending); end
    total++; if (q1 !== 3'd1 || q4 !== 3'd4 || q6 !== 3'd6) begin bad++; $display("FAIL full_q got=%0d,%0d,%0d exp=1,4,6", q1, q4, q6); end
  endtask

  initial begin
    test_reset();
    test_init_issue_cdb();
    test_multi_match();
    test_rename();
    test_same_cycle();
    test_errors();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
